// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access encodings, FSM states
// and the byte-enable pattern helper.
package lsu_pkg;

  // funct3 access encodings; bits [1:0] give log2 of the access size in bytes.
  localparam logic [2:0] Funct3B    = 3'b000;
  localparam logic [2:0] Funct3H    = 3'b001;
  localparam logic [2:0] Funct3W    = 3'b010;
  localparam logic [2:0] Funct3D    = 3'b011;
  localparam logic [2:0] Funct3Bu   = 3'b100;
  localparam logic [2:0] Funct3Hu   = 3'b101;
  localparam logic [2:0] Funct3Wu   = 3'b110;
  localparam logic [2:0] Funct3Rsvd = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StRsp
  } lsu_state_e;

  // Byte-enable pattern for an access of the given size, anchored at lane 0.
  function automatic logic [7:0] be_mask(input logic [1:0] size);
    logic [7:0] mask;
    unique case (size)
      2'b00:   mask = 8'h01;
      2'b01:   mask = 8'h03;
      2'b10:   mask = 8'h0f;
      default: mask = 8'hff;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core-side request/response and bus-side handshake signals of the load/store unit.
// The slave modport is the LSU itself; the master modport is its environment.
interface lsu_ctrl_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;

  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN/8-1:0] bus_be;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_ack;
  logic [XLEN-1:0]   bus_rdata;

  modport slave (
    input  req_valid, req_we, req_type, req_addr, req_wdata, bus_ack, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport master (
    output req_valid, req_we, req_type, req_addr, req_wdata, bus_ack, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed lanes of a full-width bus word down to
// bit 0, truncates to the access size and sign- or zero-extends to XLEN.
module lsu_load_align #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned OffW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [OffW-1:0] off,
  input  logic [2:0]      req_type,
  output logic [XLEN-1:0] rsp_rdata
);

  logic [XLEN-1:0] shifted;
  logic            sign_bit;
  int unsigned     nbits;

  // Lane shift, then keep nbits of data and fill the rest with the extension bit.
  always_comb begin
    shifted   = rdata >> {off, 3'b000};
    nbits     = 32'd8 << req_type[1:0];
    rsp_rdata = '0;
    unique case (req_type[1:0])
      2'b00:   sign_bit = shifted[7];
      2'b01:   sign_bit = shifted[15];
      2'b10:   sign_bit = shifted[31];
      default: sign_bit = shifted[XLEN-1];
    endcase
    // Unsigned variants (bu/hu/wu) have funct3[2] set.
    sign_bit = sign_bit & ~req_type[2];
    for (int unsigned i = 0; i < XLEN; i++) begin
      rsp_rdata[i] = (i < nbits) ? shifted[i] : sign_bit;
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit between execute and the RAM/IO bus: valid/ready request intake,
// legality checking, byte-enable and lane generation, a wait-state tolerant bus
// handshake with timeout, and a one-cycle registered response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned TIMEOUT_W = 8
) (
  input logic       clk,
  input logic       rst_n,
  lsu_ctrl_if.slave lsu
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OffW = $clog2(NB);
  // Counter value on the last allowed BUS cycle; the next increment reaches all-ones.
  localparam logic [TIMEOUT_W-1:0] CntLast = {{(TIMEOUT_W - 1){1'b1}}, 1'b0};

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("lsu_ctrl: XLEN must be 32 or 64");
  end
  if (ADDR_W < OffW + 1) begin : g_bad_addr_w
    $error("lsu_ctrl: ADDR_W too small for XLEN");
  end
  if (TIMEOUT_W < 2) begin : g_bad_timeout_w
    $error("lsu_ctrl: TIMEOUT_W must be at least 2");
  end

  lsu_state_e            state_q;
  logic [TIMEOUT_W-1:0]  cnt_q;
  logic                  we_q;
  logic [2:0]            type_q;
  logic [OffW-1:0]       off_q;

  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [XLEN-1:0]       rsp_rdata_q;
  logic                  bus_req_q;
  logic                  bus_we_q;
  logic [ADDR_W-1:0]     bus_addr_q;
  logic [NB-1:0]         bus_be_q;
  logic [XLEN-1:0]       bus_wdata_q;

  logic [OffW-1:0]       req_off;
  logic [1:0]            req_size;
  logic                  req_illegal;
  logic [NB-1:0]         req_be;
  logic [XLEN-1:0]       req_bus_wdata;
  logic [ADDR_W-1:0]     req_bus_addr;
  logic [XLEN-1:0]       load_data;

  // Decode the presented request: legality plus its bus-side address, lanes and data.
  always_comb begin
    req_off     = lsu.req_addr[OffW-1:0];
    req_size    = lsu.req_type[1:0];
    req_illegal = 1'b0;
    if (lsu.req_type == Funct3Rsvd) begin
      req_illegal = 1'b1;
    end
    if (XLEN == 32 && (lsu.req_type == Funct3D || lsu.req_type == Funct3Wu)) begin
      req_illegal = 1'b1;
    end
    // Stores have no unsigned variants.
    if (lsu.req_we && lsu.req_type[2]) begin
      req_illegal = 1'b1;
    end
    unique case (req_size)
      2'b01:   if (lsu.req_addr[0]) req_illegal = 1'b1;
      2'b10:   if (lsu.req_addr[1:0] != 2'b00) req_illegal = 1'b1;
      2'b11:   if (lsu.req_addr[2:0] != 3'b000) req_illegal = 1'b1;
      default: ;
    endcase
    req_be                    = NB'(be_mask(req_size)) << req_off;
    req_bus_wdata             = lsu.req_wdata << {req_off, 3'b000};
    req_bus_addr              = lsu.req_addr;
    req_bus_addr[OffW-1:0]    = '0;
  end

  lsu_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata    (lsu.bus_rdata),
    .off      (off_q),
    .req_type (type_q),
    .rsp_rdata(load_data)
  );

  // Control FSM; every interface output is a register updated only on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      type_q      <= 3'b000;
      off_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lsu.req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= lsu.req_we;
            type_q      <= lsu.req_type;
            off_q       <= req_off;
            if (req_illegal) begin
              state_q     <= StRsp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= StBus;
              cnt_q       <= '0;
              bus_req_q   <= 1'b1;
              bus_we_q    <= lsu.req_we;
              bus_addr_q  <= req_bus_addr;
              bus_be_q    <= req_be;
              bus_wdata_q <= req_bus_wdata;
            end
          end
        end
        StBus: begin
          // An ack on the saturating edge still completes normally.
          if (lsu.bus_ack) begin
            state_q     <= StRsp;
            bus_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : load_data;
          end else begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
            if (cnt_q == CntLast) begin
              state_q     <= StRsp;
              bus_req_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        StRsp: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lsu.req_ready = req_ready_q;
  assign lsu.rsp_valid = rsp_valid_q;
  assign lsu.rsp_err   = rsp_err_q;
  assign lsu.rsp_rdata = rsp_rdata_q;
  assign lsu.bus_req   = bus_req_q;
  assign lsu.bus_we    = bus_we_q;
  assign lsu.bus_addr  = bus_addr_q;
  assign lsu.bus_be    = bus_be_q;
  assign lsu.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: an RV32 instance (short timeout) and an RV64 instance.
// Stimulus pushes expected responses; per-instance monitors pop and compare them.
module tb_lsu_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   hs_cyc = 0;
  int   prev_hs;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  lsu_ctrl_if #(.XLEN(32), .ADDR_W(32)) ia ();
  lsu_ctrl_if #(.XLEN(64), .ADDR_W(32)) ib ();

  lsu_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT_W(3)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .lsu  (ia)
  );

  lsu_ctrl #(.XLEN(64), .ADDR_W(32), .TIMEOUT_W(4)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .lsu  (ib)
  );

  typedef struct {
    string       name;
    logic        err;
    logic [63:0] rdata;
    int          rsp_cyc;
    int          bus_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? ia.req_ready : ib.req_ready;
  endfunction
  function automatic logic get_rsp_valid(input int d);
    return (d == 0) ? ia.rsp_valid : ib.rsp_valid;
  endfunction
  function automatic logic get_rsp_err(input int d);
    return (d == 0) ? ia.rsp_err : ib.rsp_err;
  endfunction
  function automatic logic [63:0] get_rsp_rdata(input int d);
    return (d == 0) ? {32'h0, ia.rsp_rdata} : ib.rsp_rdata;
  endfunction
  function automatic logic get_bus_req(input int d);
    return (d == 0) ? ia.bus_req : ib.bus_req;
  endfunction
  function automatic logic get_bus_we(input int d);
    return (d == 0) ? ia.bus_we : ib.bus_we;
  endfunction
  function automatic logic [31:0] get_bus_addr(input int d);
    return (d == 0) ? ia.bus_addr : ib.bus_addr;
  endfunction
  function automatic logic [7:0] get_bus_be(input int d);
    return (d == 0) ? {4'h0, ia.bus_be} : ib.bus_be;
  endfunction
  function automatic logic [63:0] get_bus_wdata(input int d);
    return (d == 0) ? {32'h0, ia.bus_wdata} : ib.bus_wdata;
  endfunction

  task automatic drive_req(input int d, input logic v, input logic we, input logic [2:0] t,
                           input logic [31:0] addr, input logic [63:0] wdata);
    if (d == 0) begin
      ia.req_valid = v;
      ia.req_we    = we;
      ia.req_type  = t;
      ia.req_addr  = addr;
      ia.req_wdata = wdata[31:0];
    end else begin
      ib.req_valid = v;
      ib.req_we    = we;
      ib.req_type  = t;
      ib.req_addr  = addr;
      ib.req_wdata = wdata;
    end
  endtask

  task automatic drive_ack(input int d, input logic ack, input logic [63:0] rdata);
    if (d == 0) begin
      ia.bus_ack   = ack;
      ia.bus_rdata = rdata[31:0];
    end else begin
      ib.bus_ack   = ack;
      ib.bus_rdata = rdata;
    end
  endtask

  // Present a request until accepted; optionally push its expected response.
  task automatic issue(input int d, input logic we, input logic [2:0] t, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic eerr, input logic [63:0] erdata,
                       input int lat, input int nbus, input bit push, input string name);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    drive_req(d, 1'b1, we, t, addr, wdata);
    while (!get_ready(d) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL %s: req_ready never seen, got 0 expected 1", name);
    end
    hs_cyc = cyc;
    if (push) begin
      e.name    = name;
      e.err     = eerr;
      e.rdata   = erdata;
      e.rsp_cyc = cyc + lat;
      e.bus_cyc = nbus;
      if (d == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
    @(posedge clk);
    #1 drive_req(d, 1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
  endtask

  // Check bus outputs in the first BUS cycle, then ack after the given wait states.
  task automatic bus(input int d, input int waits, input bit ack, input logic [63:0] rdata,
                     input logic [31:0] eaddr, input logic [7:0] ebe, input logic [63:0] ewdata,
                     input logic ewe, input string name);
    @(negedge clk);
    chk({name, " bus_req"}, 64'(get_bus_req(d)), 64'd1);
    chk({name, " bus_addr"}, 64'(get_bus_addr(d)), 64'(eaddr));
    chk({name, " bus_be"}, 64'(get_bus_be(d)), 64'(ebe));
    chk({name, " bus_wdata"}, get_bus_wdata(d), ewdata);
    chk({name, " bus_we"}, 64'(get_bus_we(d)), 64'(ewe));
    if (ack) begin
      repeat (waits) @(negedge clk);
      drive_ack(d, 1'b1, rdata);
      @(negedge clk);
      drive_ack(d, 1'b0, 64'h0);
    end
  endtask

  task automatic monitor(input int d);
    int   bus_cnt;
    exp_t e;
    bus_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus_cnt = 0;
      end else begin
        if (get_bus_req(d)) bus_cnt++;
        if (get_rsp_valid(d)) begin
          if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected rsp_valid: got 1 expected 0 at cycle %0d", d, cyc);
          end else begin
            if (d == 0) e = q_a.pop_front();
            else e = q_b.pop_front();
            chk({e.name, " rsp_err"}, 64'(get_rsp_err(d)), 64'(e.err));
            chk({e.name, " rsp_rdata"}, get_rsp_rdata(d), e.rdata);
            chk({e.name, " rsp cycle"}, 64'(cyc), 64'(e.rsp_cyc));
            chk({e.name, " bus_req cycles"}, 64'(bus_cnt), 64'(e.bus_cyc));
          end
          bus_cnt = 0;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
    drive_req(1, 1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
    drive_ack(0, 1'b0, 64'h0);
    drive_ack(1, 1'b0, 64'h0);
    repeat (2) @(negedge clk);
    chk("rst req_ready", 64'(ia.req_ready), 64'd1);
    chk("rst rsp_valid", 64'(ia.rsp_valid), 64'd0);
    chk("rst rsp_err", 64'(ia.rsp_err), 64'd0);
    chk("rst rsp_rdata", 64'(ia.rsp_rdata), 64'd0);
    chk("rst bus_req", 64'(ia.bus_req), 64'd0);
    chk("rst bus_we", 64'(ia.bus_we), 64'd0);
    chk("rst bus_addr", 64'(ia.bus_addr), 64'd0);
    chk("rst bus_be", 64'(ia.bus_be), 64'd0);
    chk("rst bus_wdata", 64'(ia.bus_wdata), 64'd0);
    chk("rst b req_ready", 64'(ib.req_ready), 64'd1);
    chk("rst b bus_req", 64'(ib.bus_req), 64'd0);
    rst_n = 1'b1;

    // RV32 instance
    issue(0, 1'b1, 3'b000, 32'h1003, 64'hA5, 1'b0, 64'h0, 2, 1, 1'b1, "sb");
    bus(0, 0, 1'b1, 64'h0, 32'h1000, 8'h08, 64'hA500_0000, 1'b1, "sb");
    prev_hs = hs_cyc;
    issue(0, 1'b0, 3'b001, 32'h2002, 64'h0, 1'b0, 64'hFFFF_8001, 2, 1, 1'b1, "lh");
    chk("b2b after bus rsp", 64'(hs_cyc), 64'(prev_hs + 3));
    bus(0, 0, 1'b1, 64'h8001_7FFF, 32'h2000, 8'h0C, 64'h0, 1'b0, "lh");
    @(negedge clk);
    chk("hold rsp_rdata", 64'(ia.rsp_rdata), 64'hFFFF_8001);
    chk("hold rsp_valid low", 64'(ia.rsp_valid), 64'd0);
    chk("hold bus_addr", 64'(ia.bus_addr), 64'h2000);
    issue(0, 1'b0, 3'b101, 32'h2002, 64'h0, 1'b0, 64'h0000_8001, 2, 1, 1'b1, "lhu");
    bus(0, 0, 1'b1, 64'h8001_7FFF, 32'h2000, 8'h0C, 64'h0, 1'b0, "lhu");
    issue(0, 1'b0, 3'b000, 32'h5001, 64'h0, 1'b0, 64'hFFFF_FF80, 2, 1, 1'b1, "lb");
    bus(0, 0, 1'b1, 64'h0000_80FF, 32'h5000, 8'h02, 64'h0, 1'b0, "lb");
    issue(0, 1'b0, 3'b100, 32'h5001, 64'h0, 1'b0, 64'h0000_0080, 2, 1, 1'b1, "lbu");
    bus(0, 0, 1'b1, 64'h0000_80FF, 32'h5000, 8'h02, 64'h0, 1'b0, "lbu");
    issue(0, 1'b1, 3'b010, 32'h6000, 64'hDEAD_BEEF, 1'b0, 64'h0, 4, 3, 1'b1, "sw ws2");
    bus(0, 2, 1'b1, 64'h0, 32'h6000, 8'h0F, 64'hDEAD_BEEF, 1'b1, "sw ws2");

    // Illegal accesses: one-cycle error response, no bus cycle.
    issue(0, 1'b0, 3'b010, 32'h3001, 64'h0, 1'b1, 64'h0, 1, 0, 1'b1, "lw misaligned");
    prev_hs = hs_cyc;
    issue(0, 1'b1, 3'b011, 32'h0000, 64'h1, 1'b1, 64'h0, 1, 0, 1'b1, "sd rv32");
    chk("b2b after err rsp", 64'(hs_cyc), 64'(prev_hs + 2));
    issue(0, 1'b1, 3'b100, 32'h0000, 64'h1, 1'b1, 64'h0, 1, 0, 1'b1, "store unsigned");
    issue(0, 1'b0, 3'b111, 32'h0000, 64'h0, 1'b1, 64'h0, 1, 0, 1'b1, "type 111");
    repeat (2) @(negedge clk);
    chk("bus_addr held over errors", 64'(ia.bus_addr), 64'h6000);

    // Timeout at 7 bus cycles, then ack landing on the 7th cycle.
    issue(0, 1'b0, 3'b010, 32'h0010, 64'h0, 1'b1, 64'h0, 8, 7, 1'b1, "timeout");
    bus(0, 0, 1'b0, 64'h0, 32'h0010, 8'h0F, 64'h0, 1'b0, "timeout");
    repeat (8) @(negedge clk);
    issue(0, 1'b0, 3'b010, 32'h0014, 64'h0, 1'b0, 64'h1234_5678, 8, 7, 1'b1, "ack on 7th");
    bus(0, 6, 1'b1, 64'h1234_5678, 32'h0014, 8'h0F, 64'h0, 1'b0, "ack on 7th");

    // Reset in the middle of a bus access: no response, idle afterwards.
    issue(0, 1'b0, 3'b010, 32'h0020, 64'h0, 1'b0, 64'h0, 0, 0, 1'b0, "reset mid-bus");
    @(negedge clk);
    chk("pre-reset bus_req", 64'(ia.bus_req), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset bus_req", 64'(ia.bus_req), 64'd0);
    chk("async reset req_ready", 64'(ia.req_ready), 64'd1);
    chk("async reset rsp_valid", 64'(ia.rsp_valid), 64'd0);
    chk("async reset bus_addr", 64'(ia.bus_addr), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset req_ready", 64'(ia.req_ready), 64'd1);
    issue(0, 1'b0, 3'b010, 32'h0024, 64'h0, 1'b0, 64'hCAFE_F00D, 3, 2, 1'b1, "lw after reset");
    bus(0, 1, 1'b1, 64'hCAFE_F00D, 32'h0024, 8'h0F, 64'h0, 1'b0, "lw after reset");

    // RV64 instance
    issue(1, 1'b0, 3'b011, 32'h4008, 64'h0, 1'b0, 64'h8000_0000_0000_0001, 5, 4, 1'b1, "ld ws3");
    bus(1, 3, 1'b1, 64'h8000_0000_0000_0001, 32'h4008, 8'hFF, 64'h0, 1'b0, "ld ws3");
    issue(1, 1'b0, 3'b110, 32'h4004, 64'h0, 1'b0, 64'h0000_0000_8000_0000, 2, 1, 1'b1, "lwu");
    bus(1, 0, 1'b1, 64'h8000_0000_0000_0001, 32'h4000, 8'hF0, 64'h0, 1'b0, "lwu");
    issue(1, 1'b0, 3'b010, 32'h4004, 64'h0, 1'b0, 64'hFFFF_FFFF_8000_0000, 2, 1, 1'b1, "lw64");
    bus(1, 0, 1'b1, 64'h8000_0000_0000_0001, 32'h4000, 8'hF0, 64'h0, 1'b0, "lw64");
    issue(1, 1'b1, 3'b001, 32'h4006, 64'hBEEF, 1'b0, 64'h0, 2, 1, 1'b1, "sh64");
    bus(1, 0, 1'b1, 64'h0, 32'h4000, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b1, "sh64");
    issue(1, 1'b0, 3'b011, 32'h4004, 64'h0, 1'b1, 64'h0, 1, 0, 1'b1, "ld misaligned");
    issue(1, 1'b1, 3'b011, 32'h4010, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 3, 2, 1'b1, "sd");
    bus(1, 1, 1'b1, 64'h0, 32'h4010, 8'hFF, 64'h1122_3344_5566_7788, 1'b1, "sd");

    repeat (4) @(negedge clk);
    chk("dut a responses outstanding", 64'(q_a.size()), 64'd0);
    chk("dut b responses outstanding", 64'(q_b.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Parametrised load/store unit placed between the core's execute stage and the RAM/IO bus. It replaces the fixed single-cycle `ram_or_io_*` path with a valid/ready request, a wait-state-tolerant bus handshake, byte-enable generation, alignment checking, load sign/zero extension and a bus timeout. It supports XLEN = 32 and 64, so the same block serves the RV32 core and a future RV64 core.

## Interface
Parameters:
- XLEN, 32, data width; only 32 or 64 are legal.
- ADDR_W, 32, byte address width; must be ≥ log2(XLEN/8)+1.
- TIMEOUT_W, 8, width of the bus wait counter; must be ≥ 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept an access.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  funct3 encoding: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal type or timeout; valid with rsp_valid.
- bus_req  out  1  bus access request, held until acknowledged.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  address aligned to XLEN/8 bytes (low bits zero).
- bus_be  out  XLEN/8  byte enables.
- bus_wdata  out  XLEN  lane-shifted store data.
- bus_ack  in  1  bus completes the access this cycle.
- bus_rdata  in  XLEN  full-width read data, valid with bus_ack.

## Operation
- States: IDLE, BUS, RSP.
- IDLE: req_ready = 1. A handshake (req_valid & req_ready) registers we, type, addr and wdata.
  - Legality error → RSP with err = 1. No bus cycle is issued.
  - Otherwise → BUS.
- Legality errors:
  - Type 111.
  - Type 011 or 110 when XLEN = 32.
  - Store with type[2] = 1.
  - Misalignment: h/hu with addr[0] ≠ 0, w/wu with addr[1:0] ≠ 0, d with addr[2:0] ≠ 0.
- BUS: bus_req = 1 and all bus_* outputs are stable.
  - off = addr mod (XLEN/8).
  - bus_be = {1, 3, F, FF}[size] << off.
  - bus_wdata = wdata << (8·off).
  - On bus_ack: capture bus_rdata and go to RSP.
  - Wait counter increments each BUS cycle without ack. At all-ones it aborts to RSP with err = 1 and bus_req drops.
- RSP: rsp_valid = 1 for exactly one cycle, then IDLE.
  - Loads: rsp_rdata = (rdata >> 8·off), truncated to the access size. Sign-extended for b/h/w/d, zero-extended for bu/hu/wu.
- Outside BUS, bus_req = 0 and the other bus outputs hold their last values.
- Outside RSP, rsp_valid = 0 and rsp_rdata/rsp_err hold their last values.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_err 0, rsp_rdata 0, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, counter 0.
- Handshake in cycle 0 → bus_req in cycle 1. With zero wait states, bus_ack arrives in cycle 1 and rsp_valid in cycle 2.
- Each bus wait state adds one cycle.
- An error access gives rsp_valid in cycle 1.
- Next request accepted in the cycle after rsp_valid. There is no overlap and no response backpressure.
- Timeout: bus_req is high for exactly 2^TIMEOUT_W − 1 cycles, then rsp_valid/err fires on the next cycle.
- bus_ack on the same edge the counter saturates: the ack wins (normal response, err = 0).
- bus_ack outside BUS is ignored.
- rst_n low in any state forces reset values immediately. bus_req drops asynchronously and the access is lost without a response.

## Structure
- Package lsu_pkg holds:
  - funct3 size/type localparams;
  - state enum (IDLE/BUS/RSP);
  - a byte-enable mask function.
- Sub-module lsu_load_align (combinational): inputs rdata, off, type; output extended rsp_rdata. Instantiated once.
- FSM, counter and request registers live in lsu_ctrl.

## Test plan
- XLEN = 32, store sb at addr 0x1003, wdata 0x000000A5, ack in cycle 1 → bus_addr 0x1000, bus_be 1000, bus_wdata 0xA5000000, rsp_valid cycle 2, err 0.
- XLEN = 32, load lh at 0x2002, bus_rdata 0x8001_7FFF → rsp_rdata 0xFFFF8001. Same access with lhu → 0x00008001.
- Load lw at 0x3001 → rsp_valid cycle 1, err 1, bus_req never asserts. Also sd with XLEN = 32 → err 1.
- TIMEOUT_W = 3, bus_ack never asserted → bus_req high exactly 7 cycles, then rsp_valid with err 1, rsp_rdata 0. Ack arriving on the 7th cycle → err 0.
- XLEN = 64, ld at 0x4008, 3 wait states, bus_rdata 0x8000_0000_0000_0001 → rsp_valid 5 cycles after the handshake, data unchanged, bus_be 0xFF. lwu at 0x4004 → 0x0000_0000_8000_0000.
- rst_n pulsed low mid-BUS → bus_req 0 immediately, no rsp_valid, req_ready 1 after release. A back-to-back request is accepted on the cycle after rsp_valid.
